// File: rtl/tx_pkg.sv
// Shared definitions for the framed parallel-in/serial-out transmitter.
//   tx_state_t : frame sequencing states
//   *_LEVEL    : serial line levels for idle, start and stop bits
//   line_level : serial line level for a given state and current data bit
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic logic line_level(input tx_state_t state, input logic data_bit);
    logic level;
    level = IDLE_LEVEL;
    unique case (state)
      IDLE:    level = IDLE_LEVEL;
      START:   level = START_LEVEL;
      DATA:    level = data_bit;
      STOP:    level = STOP_LEVEL;
      default: level = IDLE_LEVEL;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer for the serial transmitter.
//   clk     : clock, counts on posedge
//   reset_n : asynchronous active-low reset
//   clear   : hold the counter at zero (used while the line is idle)
//   tick    : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  // Wrapping at LAST_CNT keeps the counter inside its width for any CLKS_PER_BIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter.
// Sends each accepted word as: start bit (0), DATA_W data bits, stop bit (1), every bit held
// for CLKS_PER_BIT cycles. All outputs come straight from flops.
//   clk     : clock
//   reset_n : asynchronous active-low reset; aborts any frame in progress
//   d_in    : parallel word, latched on accept (d_valid && d_ready)
//   d_valid : producer has a word on d_in
//   d_ready : transmitter idle and able to accept a word
//   q_out   : serial line, idles high
//   busy    : frame in progress
//   done    : one-cycle pulse in the first idle cycle after a stop bit
module piso_serial_tx
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              q_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              q_out_q, q_out_d;
  logic              d_ready_q, d_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              data_bit;

  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (d_valid && d_ready_q) begin
          state_d   = START;
          shift_d   = d_in;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the line changes on the same edge as
  // the state, keeping frame timing exact while still driving outputs from flops.
  always_comb begin
    data_bit  = LSB_FIRST ? shift_d[0] : shift_d[DATA_W-1];
    q_out_d   = line_level(state_d, data_bit);
    d_ready_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      q_out_q   <= IDLE_LEVEL;
      d_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      q_out_q   <= q_out_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign q_out   = q_out_q;
  assign d_ready = d_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: three instances cover LSB-first (8 bits, 4 clk/bit),
// MSB-first (8 bits, 4 clk/bit) and the single-cycle-bit case (4 bits, 1 clk/bit).
module tb_piso_serial_tx;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  // LSB-first, DATA_W=8, CLKS_PER_BIT=4
  logic [7:0] d_in_a;
  logic       d_valid_a, d_ready_a, q_out_a, busy_a, done_a;
  // MSB-first, DATA_W=8, CLKS_PER_BIT=4
  logic [7:0] d_in_m;
  logic       d_valid_m, d_ready_m, q_out_m, busy_m, done_m;
  // LSB-first, DATA_W=4, CLKS_PER_BIT=1
  logic [3:0] d_in_c;
  logic       d_valid_c, d_ready_c, q_out_c, busy_c, done_c;

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .d_in(d_in_a), .d_valid(d_valid_a),
    .d_ready(d_ready_a), .q_out(q_out_a), .busy(busy_a), .done(done_a)
  );

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) u_dut_m (
    .clk(clk), .reset_n(reset_n), .d_in(d_in_m), .d_valid(d_valid_m),
    .d_ready(d_ready_m), .q_out(q_out_m), .busy(busy_m), .done(done_m)
  );

  piso_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .d_in(d_in_c), .d_valid(d_valid_c),
    .d_ready(d_ready_c), .q_out(q_out_c), .busy(busy_c), .done(done_c)
  );

  // Instance under observation: 0 = a, 1 = m, 2 = c
  int   sel;
  logic q_s, ready_s, busy_s, done_s;

  always_comb begin
    q_s     = q_out_a;
    ready_s = d_ready_a;
    busy_s  = busy_a;
    done_s  = done_a;
    if (sel == 1) begin
      q_s     = q_out_m;
      ready_s = d_ready_m;
      busy_s  = busy_m;
      done_s  = done_m;
    end else if (sel == 2) begin
      q_s     = q_out_c;
      ready_s = d_ready_c;
      busy_s  = busy_c;
      done_s  = done_c;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_q"}, q_s, 1'b1);
    chk({tag, "_ready"}, ready_s, 1'b1);
    chk({tag, "_busy"}, busy_s, 1'b0);
    chk({tag, "_done"}, done_s, 1'b0);
  endtask

  // Checks a frame that starts in the current cycle; bits[0] is the first bit on the line.
  // Ends positioned in the done cycle, after checking it.
  task automatic chk_frame(input string tag, input logic [15:0] bits, input int nbits,
                           input int cpb);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s_q_b%0d_c%0d", tag, b, c), q_s, bits[b]);
        chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), busy_s, 1'b1);
        chk($sformatf("%s_ready_b%0d_c%0d", tag, b, c), ready_s, 1'b0);
        chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), done_s, 1'b0);
        step();
      end
    end
    chk({tag, "_done_pulse"}, done_s, 1'b1);
    chk({tag, "_done_ready"}, ready_s, 1'b1);
    chk({tag, "_done_busy"}, busy_s, 1'b0);
    chk({tag, "_done_q"}, q_s, 1'b1);
  endtask

  initial begin
    sel       = 0;
    reset_n   = 1'b0;
    d_in_a    = '0;
    d_valid_a = 1'b0;
    d_in_m    = '0;
    d_valid_m = 1'b0;
    d_in_c    = '0;
    d_valid_c = 1'b0;

    // Reset held for three cycles, then idle line with no valid
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst");
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("idle");
    end

    // Single LSB-first frame of 8'hA5: line 0,1,0,1,0,0,1,0,1,1
    d_in_a    = 8'hA5;
    d_valid_a = 1'b1;
    step();
    d_valid_a = 1'b0;
    d_in_a    = 8'h5A;  // changing the input mid-frame must not disturb the latched word
    chk_frame("a5", 16'b0000_0011_0100_1010, 10, 4);
    step();
    chk_idle("a5_after");

    // MSB-first 8'h81: data bits 1,0,0,0,0,0,0,1
    sel       = 1;
    d_in_m    = 8'h81;
    d_valid_m = 1'b1;
    step();
    d_valid_m = 1'b0;
    chk_frame("m81", 16'b0000_0011_0000_0010, 10, 4);
    step();
    chk_idle("m81_after");

    // Back-to-back: valid held high, 8'h3C then 8'hC3
    sel       = 0;
    d_in_a    = 8'h3C;
    d_valid_a = 1'b1;
    step();
    d_in_a    = 8'hC3;  // stays valid through the frame; only taken in the done cycle
    chk_frame("b3c", 16'b0000_0010_0111_1000, 10, 4);
    step();
    d_valid_a = 1'b0;
    chk_frame("bc3", 16'b0000_0011_1000_0110, 10, 4);
    step();
    chk_idle("bc3_after");

    // Abort an 8'hFF frame during its third data bit
    d_in_a    = 8'hFF;
    d_valid_a = 1'b1;
    step();
    d_valid_a = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("abort_pre_q", q_out_a, 1'b1);
    chk("abort_pre_busy", busy_a, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_async_q", q_out_a, 1'b1);
    chk("abort_async_busy", busy_a, 1'b0);
    chk("abort_async_done", done_a, 1'b0);
    step();
    step();
    chk_idle("abort_rst");
    reset_n = 1'b1;
    // Window covers where the aborted frame's done pulse would otherwise have fallen
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("abort_nodone_%0d", i), done_a, 1'b0);
      chk($sformatf("abort_idle_q_%0d", i), q_out_a, 1'b1);
    end
    d_in_a    = 8'h00;
    d_valid_a = 1'b1;
    step();
    d_valid_a = 1'b0;
    chk_frame("a00", 16'b0000_0010_0000_0000, 10, 4);
    step();
    chk_idle("a00_after");

    // One clock per bit, 4'b1010: line 0,0,1,0,1,1, done on the 7th cycle
    sel       = 2;
    d_in_c    = 4'b1010;
    d_valid_c = 1'b1;
    step();
    d_valid_c = 1'b0;
    chk_frame("c1010", 16'b0000_0000_0011_0100, 6, 1);
    step();
    chk_idle("c1010_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
